ahb_rw_master: RTL and testbench

- Self-checking AHB-Lite bus master for hardware bring-up of the SDRAM controller (ahb_lite_sdram).
- Writes a deterministic pattern to a block of words, then reads it back repeatedly and compares.
- Exposes error/pass counters and status flags for LEDs or a debug port.
- Sits between the clock/reset source and the slave's AHB-Lite port; it is the only master.

---
 rtl/ahb_rw_master_pkg.sv | 23 ++
 rtl/ahb_rw_pattern_gen.sv | 20 ++
 rtl/ahb_rw_master.sv | 167 ++++++++++++++++
 tb/tb_ahb_rw_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_rw_master_pkg.sv
// Shared AHB-Lite encodings and the master's state type for the SDRAM bring-up master.
// The data pattern is the seed XORed with the byte address, so expected data is address-derived.
package ahb_rw_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam int         IDX_W         = 8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_W_ADDR,
        ST_W_DATA,
        ST_R_ADDR,
        ST_R_DATA
    } state_t;

    function automatic logic [31:0] pattern_data(input logic [31:0] seed, input logic [31:0] addr);
        return seed ^ addr;
    endfunction

endpackage

// File: rtl/ahb_rw_pattern_gen.sv
// Combinational address/data generator: A(i) = (start+i)<<2, D(i) = seed ^ A(i).
// Address arithmetic wraps modulo 2^32.
module ahb_rw_pattern_gen
    import ahb_rw_master_pkg::*;
#(
    parameter logic [31:0] DATA_SEED = 32'hA5A50000
) (
    input  logic [31:0]      i_start_addr,
    input  logic [IDX_W-1:0] i_index,
    output logic [31:0]      o_addr,
    output logic [31:0]      o_data
);

    logic [31:0] w_word;

    assign w_word = i_start_addr + {{(32-IDX_W){1'b0}}, i_index};
    assign o_addr = {w_word[29:0], 2'b00};
    assign o_data = pattern_data(DATA_SEED, o_addr);

endmodule

// File: rtl/ahb_rw_master.sv
// AHB-Lite bring-up master: writes a pattern once, then reads it back forever and counts errors.
// All bus outputs are registered; one single transfer is outstanding at most.
module ahb_rw_master
    import ahb_rw_master_pkg::*;
#(
    parameter int          WORD_COUNT = 16,
    parameter logic [31:0] DATA_SEED  = 32'hA5A50000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HSEL,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] STARTADDR,
    output logic [31:0] ERRCOUNT,
    output logic [7:0]  CHKCOUNT,
    output logic        S_WRITE,
    output logic        S_CHECK,
    output logic        S_SUCCESS,
    output logic        S_FAILED
);

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_index, w_index_next;
    logic [1:0]       r_htrans, w_htrans_next;
    logic             r_hsel, w_hsel_next;
    logic             r_hwrite, w_hwrite_next;
    logic [31:0]      r_haddr, w_haddr_next;
    logic [31:0]      r_hwdata, w_hwdata_next;
    logic [31:0]      r_errcount;
    logic [7:0]       r_chkcount;
    logic             r_pass_done;
    logic             r_s_write, r_s_check;
    logic             w_err_inc, w_chk_inc;
    logic             w_xfer_done, w_last;
    logic [31:0]      w_pat_addr, w_pat_data;

    // Index for the transfer being set up this cycle; the generator follows it.
    assign w_xfer_done  = HREADY && (r_state == ST_W_DATA || r_state == ST_R_DATA);
    assign w_last       = (r_index == IDX_W'(WORD_COUNT - 1));
    assign w_index_next = !w_xfer_done ? r_index : (w_last ? '0 : r_index + IDX_W'(1));

    ahb_rw_pattern_gen #(
        .DATA_SEED(DATA_SEED)
    ) u_pattern_gen (
        .i_start_addr(STARTADDR),
        .i_index     (w_index_next),
        .o_addr      (w_pat_addr),
        .o_data      (w_pat_data)
    );

    always_comb begin
        w_state_next  = r_state;
        w_htrans_next = r_htrans;
        w_hsel_next   = r_hsel;
        w_hwrite_next = r_hwrite;
        w_haddr_next  = r_haddr;
        w_hwdata_next = r_hwdata;
        w_err_inc     = 1'b0;
        w_chk_inc     = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_state_next  = ST_W_ADDR;
                w_htrans_next = HTRANS_NONSEQ;
                w_hsel_next   = 1'b1;
                w_hwrite_next = 1'b1;
                w_haddr_next  = w_pat_addr;
            end
            ST_W_ADDR, ST_R_ADDR: begin
                // A stalled address phase is withdrawn and re-issued once the slave is ready.
                if (r_htrans == HTRANS_NONSEQ) begin
                    w_htrans_next = HTRANS_IDLE;
                    w_hsel_next   = 1'b0;
                    if (HREADY) begin
                        if (r_state == ST_W_ADDR) begin
                            w_state_next  = ST_W_DATA;
                            w_hwdata_next = w_pat_data;
                        end else begin
                            w_state_next = ST_R_DATA;
                        end
                    end
                end else if (HREADY) begin
                    w_htrans_next = HTRANS_NONSEQ;
                    w_hsel_next   = 1'b1;
                end
            end
            ST_W_DATA: begin
                if (HREADY) begin
                    w_err_inc     = HRESP;
                    w_htrans_next = HTRANS_NONSEQ;
                    w_hsel_next   = 1'b1;
                    w_haddr_next  = w_pat_addr;
                    w_hwrite_next = !w_last;
                    w_state_next  = w_last ? ST_R_ADDR : ST_W_ADDR;
                end
            end
            ST_R_DATA: begin
                if (HREADY) begin
                    // HADDR still holds this word's address during its data phase.
                    w_err_inc     = HRESP || (HRDATA != pattern_data(DATA_SEED, r_haddr));
                    w_chk_inc     = w_last;
                    w_htrans_next = HTRANS_NONSEQ;
                    w_hsel_next   = 1'b1;
                    w_haddr_next  = w_pat_addr;
                    w_hwrite_next = 1'b0;
                    w_state_next  = ST_R_ADDR;
                end
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= ST_INIT;
            r_index     <= '0;
            r_htrans    <= HTRANS_IDLE;
            r_hsel      <= 1'b0;
            r_hwrite    <= 1'b0;
            r_haddr     <= '0;
            r_hwdata    <= '0;
            r_errcount  <= '0;
            r_chkcount  <= '0;
            r_pass_done <= 1'b0;
            r_s_write   <= 1'b0;
            r_s_check   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_index     <= w_index_next;
            r_htrans    <= w_htrans_next;
            r_hsel      <= w_hsel_next;
            r_hwrite    <= w_hwrite_next;
            r_haddr     <= w_haddr_next;
            r_hwdata    <= w_hwdata_next;
            if (w_err_inc && (r_errcount != 32'hFFFF_FFFF)) begin
                r_errcount <= r_errcount + 32'd1;
            end
            r_chkcount  <= r_chkcount + {7'd0, w_chk_inc};
            r_pass_done <= r_pass_done | w_chk_inc;
            r_s_write   <= (w_state_next == ST_INIT) || (w_state_next == ST_W_ADDR) ||
                           (w_state_next == ST_W_DATA);
            r_s_check   <= (w_state_next == ST_R_ADDR) || (w_state_next == ST_R_DATA);
        end
    end

    assign HADDR     = r_haddr;
    assign HBURST    = HBURST_SINGLE;
    assign HSEL      = r_hsel;
    assign HSIZE     = HSIZE_WORD;
    assign HTRANS    = r_htrans;
    assign HWDATA    = r_hwdata;
    assign HWRITE    = r_hwrite;
    assign ERRCOUNT  = r_errcount;
    assign CHKCOUNT  = r_chkcount;
    assign S_WRITE   = r_s_write;
    assign S_CHECK   = r_s_check;
    assign S_SUCCESS = r_pass_done && (r_errcount == 32'd0);
    assign S_FAILED  = (r_errcount != 32'd0);

endmodule

// File: tb/tb_ahb_rw_master.sv
// Directed bench for ahb_rw_master against a small AHB-Lite memory slave with fault knobs
// (read bit-flip, write-data stall, write error response).
module tb_ahb_rw_master;

    localparam logic [31:0] NONE = 32'hFFFF_FFF0;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR, HWDATA, HRDATA, ERRCOUNT;
    logic [2:0]  HBURST, HSIZE;
    logic [1:0]  HTRANS;
    logic        HSEL, HWRITE, HREADY, HRESP;
    logic [31:0] STARTADDR = 32'd1;
    logic [7:0]  CHKCOUNT;
    logic        S_WRITE, S_CHECK, S_SUCCESS, S_FAILED;

    logic [31:0] flip_addr, stall_addr, err_addr;
    logic [31:0] mem [256];
    logic        dp_valid, dp_write;
    logic [31:0] dp_addr;
    int          wcnt;
    logic        sw_clr;
    int          sw_cycles;
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    always #5 HCLK = ~HCLK;

    ahb_rw_master #(
        .WORD_COUNT(16),
        .DATA_SEED (32'hA5A50000)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HADDR    (HADDR),
        .HBURST   (HBURST),
        .HSEL     (HSEL),
        .HSIZE    (HSIZE),
        .HTRANS   (HTRANS),
        .HWDATA   (HWDATA),
        .HWRITE   (HWRITE),
        .HRDATA   (HRDATA),
        .HREADY   (HREADY),
        .HRESP    (HRESP),
        .STARTADDR(STARTADDR),
        .ERRCOUNT (ERRCOUNT),
        .CHKCOUNT (CHKCOUNT),
        .S_WRITE  (S_WRITE),
        .S_CHECK  (S_CHECK),
        .S_SUCCESS(S_SUCCESS),
        .S_FAILED (S_FAILED)
    );

    // Memory slave: zero wait states unless a stall or error is targeted at the address.
    assign HREADY = (wcnt == 0);
    assign HRESP  = dp_valid && dp_write && (dp_addr == err_addr);
    assign HRDATA = (dp_valid && !dp_write) ?
                    (mem[dp_addr[9:2]] ^ ((dp_addr == flip_addr) ? 32'h1 : 32'h0)) : 32'h0;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 32'd0;
            wcnt     <= 0;
            for (int k = 0; k < 256; k++) mem[k] <= 32'd0;
        end else if (wcnt != 0) begin
            wcnt <= wcnt - 1;
        end else begin
            if (dp_valid && dp_write && !HRESP) mem[dp_addr[9:2]] <= HWDATA;
            dp_valid <= HSEL && (HTRANS == 2'd2);
            if (HSEL && (HTRANS == 2'd2)) begin
                dp_write <= HWRITE;
                dp_addr  <= HADDR;
                if (HWRITE && (HADDR == stall_addr)) wcnt <= 5;
            end
        end
    end

    always @(negedge HCLK) begin
        if (sw_clr) sw_cycles <= 0;
        else if (S_WRITE) sw_cycles <= sw_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic reset_and_release();
        HRESET = 1'b1;
        sw_clr = 1'b1;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        sw_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET     = 1'b1;
        sw_clr     = 1'b1;
        flip_addr  = NONE;
        stall_addr = NONE;
        err_addr   = NONE;

        // Reset values
        step(2);
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_hsel", {31'd0, HSEL}, 32'd0);
        chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_hburst", {29'd0, HBURST}, 32'd0);
        chk("rst_hsize", {29'd0, HSIZE}, 32'd2);
        chk("rst_errcount", ERRCOUNT, 32'd0);
        chk("rst_chkcount", {24'd0, CHKCOUNT}, 32'd0);
        chk("rst_status", {28'd0, S_WRITE, S_CHECK, S_SUCCESS, S_FAILED}, 32'd0);

        // Clean write pass followed by first check pass
        @(negedge HCLK);
        HRESET = 1'b0;
        sw_clr = 1'b0;
        step(1);
        $display("A: first write address phase HADDR=0x%08h", HADDR);
        chk("a_w0_htrans", {30'd0, HTRANS}, 32'd2);
        chk("a_w0_hsel", {31'd0, HSEL}, 32'd1);
        chk("a_w0_hwrite", {31'd0, HWRITE}, 32'd1);
        chk("a_w0_haddr", HADDR, 32'h0000_0004);
        chk("a_w0_swrite", {31'd0, S_WRITE}, 32'd1);
        step(1);
        chk("a_w0_idle", {30'd0, HTRANS}, 32'd0);
        chk("a_w0_hwdata", HWDATA, 32'hA5A5_0004);
        step(29);
        chk("a_w15_haddr", HADDR, 32'h0000_0040);
        chk("a_w15_htrans", {30'd0, HTRANS}, 32'd2);
        step(1);
        chk("a_w15_hwdata", HWDATA, 32'hA5A5_0040);
        chk("a_w15_swrite", {31'd0, S_WRITE}, 32'd1);
        step(1);
        $display("A: check phase begins HADDR=0x%08h HWRITE=%0d", HADDR, HWRITE);
        chk("a_r0_swrite", {31'd0, S_WRITE}, 32'd0);
        chk("a_r0_scheck", {31'd0, S_CHECK}, 32'd1);
        chk("a_r0_hwrite", {31'd0, HWRITE}, 32'd0);
        chk("a_r0_haddr", HADDR, 32'h0000_0004);
        step(30);
        chk("a_r15_haddr", HADDR, 32'h0000_0040);
        step(1);
        chk("a_pre_chkcount", {24'd0, CHKCOUNT}, 32'd0);
        chk("a_pre_success", {31'd0, S_SUCCESS}, 32'd0);
        step(1);
        $display("A: pass 1 CHKCOUNT=%0d ERRCOUNT=%0d", CHKCOUNT, ERRCOUNT);
        chk("a_chkcount", {24'd0, CHKCOUNT}, 32'd1);
        chk("a_success", {31'd0, S_SUCCESS}, 32'd1);
        chk("a_errcount", ERRCOUNT, 32'd0);
        chk("a_failed", {31'd0, S_FAILED}, 32'd0);
        chk("a_swrite_cycles", sw_cycles, 32'd32);
        chk("a_mem_0x4", mem[1], 32'hA5A5_0004);
        chk("a_mem_0x40", mem[16], 32'hA5A5_0040);

        // Corrupted read data at 0x10
        flip_addr = 32'h0000_0010;
        reset_and_release();
        step(40);
        chk("b_err_before", ERRCOUNT, 32'd0);
        step(1);
        $display("B: after read of 0x10 ERRCOUNT=%0d", ERRCOUNT);
        chk("b_err_first", ERRCOUNT, 32'd1);
        chk("b_failed", {31'd0, S_FAILED}, 32'd1);
        step(24);
        chk("b_pass1_err", ERRCOUNT, 32'd1);
        chk("b_pass1_chk", {24'd0, CHKCOUNT}, 32'd1);
        chk("b_pass1_success", {31'd0, S_SUCCESS}, 32'd0);
        step(32);
        $display("B: pass 2 CHKCOUNT=%0d ERRCOUNT=%0d", CHKCOUNT, ERRCOUNT);
        chk("b_pass2_err", ERRCOUNT, 32'd2);
        chk("b_pass2_chk", {24'd0, CHKCOUNT}, 32'd2);
        chk("b_pass2_failed", {31'd0, S_FAILED}, 32'd1);

        // Five-cycle wait state during the data phase of the write to 0x8
        flip_addr  = NONE;
        stall_addr = 32'h0000_0008;
        reset_and_release();
        step(4);
        chk("c_stall_hwdata0", HWDATA, 32'hA5A5_0008);
        chk("c_stall_htrans0", {30'd0, HTRANS}, 32'd0);
        chk("c_stall_hready", {31'd0, HREADY}, 32'd0);
        step(3);
        chk("c_stall_hwdata1", HWDATA, 32'hA5A5_0008);
        chk("c_stall_htrans1", {30'd0, HTRANS}, 32'd0);
        step(2);
        chk("c_stall_htrans2", {30'd0, HTRANS}, 32'd0);
        chk("c_stall_ready", {31'd0, HREADY}, 32'd1);
        step(1);
        $display("C: after stall HTRANS=%0d HADDR=0x%08h", HTRANS, HADDR);
        chk("c_next_htrans", {30'd0, HTRANS}, 32'd2);
        chk("c_next_haddr", HADDR, 32'h0000_000C);
        step(59);
        chk("c_pre_chkcount", {24'd0, CHKCOUNT}, 32'd0);
        step(1);
        chk("c_chkcount", {24'd0, CHKCOUNT}, 32'd1);
        chk("c_errcount", ERRCOUNT, 32'd0);
        chk("c_success", {31'd0, S_SUCCESS}, 32'd1);
        chk("c_mem_0x8", mem[2], 32'hA5A5_0008);

        // Error response on the write to 0xC (the word is then never stored)
        stall_addr = NONE;
        err_addr   = 32'h0000_000C;
        reset_and_release();
        step(6);
        chk("d_err_before", ERRCOUNT, 32'd0);
        step(1);
        $display("D: after error response ERRCOUNT=%0d HADDR=0x%08h", ERRCOUNT, HADDR);
        chk("d_err_write", ERRCOUNT, 32'd1);
        chk("d_failed", {31'd0, S_FAILED}, 32'd1);
        chk("d_continue_htrans", {30'd0, HTRANS}, 32'd2);
        chk("d_continue_haddr", HADDR, 32'h0000_0010);
        step(58);
        chk("d_pass1_err", ERRCOUNT, 32'd2);
        chk("d_pass1_chk", {24'd0, CHKCOUNT}, 32'd1);
        chk("d_pass1_success", {31'd0, S_SUCCESS}, 32'd0);

        // Asynchronous reset during check pass 3
        err_addr = NONE;
        reset_and_release();
        step(110);
        chk("e_mid_chkcount", {24'd0, CHKCOUNT}, 32'd2);
        chk("e_mid_scheck", {31'd0, S_CHECK}, 32'd1);
        HRESET = 1'b1;
        #1;
        $display("E: reset asserted mid-pass HTRANS=%0d CHKCOUNT=%0d", HTRANS, CHKCOUNT);
        chk("e_rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("e_rst_hsel", {31'd0, HSEL}, 32'd0);
        chk("e_rst_haddr", HADDR, 32'd0);
        chk("e_rst_hwdata", HWDATA, 32'd0);
        chk("e_rst_chkcount", {24'd0, CHKCOUNT}, 32'd0);
        chk("e_rst_status", {28'd0, S_WRITE, S_CHECK, S_SUCCESS, S_FAILED}, 32'd0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        step(1);
        chk("e_new_haddr", HADDR, 32'h0000_0004);
        chk("e_new_htrans", {30'd0, HTRANS}, 32'd2);
        chk("e_new_hwrite", {31'd0, HWRITE}, 32'd1);
        chk("e_new_swrite", {31'd0, S_WRITE}, 32'd1);
        step(1);
        chk("e_new_hwdata", HWDATA, 32'hA5A5_0004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
